// File: rtl/overcurrent_guard_n.sv
// rtl/overcurrent_guard_n.sv - N-channel overcurrent trip/cooldown/lockout guard; OCG_PEAK_HOLD_EN adds per-channel peak hold
module overcurrent_guard_n #(
    parameter int unsigned       N_CH      = 3,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] TRIP_TH   = DATA_W'(16'h0258),
    parameter logic [DATA_W-1:0] CLEAR_TH  = DATA_W'(16'h01F4),
    parameter int unsigned       TRIP_CNT  = 4,
    parameter int unsigned       RETRY_CYC = 50_000_000,
    parameter int unsigned       MAX_RETRY = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   sample_data,
    input  logic [N_CH-1:0]          sample_valid,
    input  logic [N_CH-1:0]          clear_lockout,
    output logic [N_CH-1:0]          relay,
    output logic [N_CH-1:0]          locked,
    output logic [N_CH-1:0]          trip_event,
    output logic [N_CH*DATA_W-1:0]   peak_data
);

    localparam int OVER_W  = (TRIP_CNT > 1) ? $clog2(TRIP_CNT) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int TIMER_W = $clog2(RETRY_CYC + 1);

    localparam logic [OVER_W-1:0]  OVER_LAST    = OVER_W'(TRIP_CNT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RETRY_CYC);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_TRIPPED = 2'd1,
        ST_LOCKOUT = 2'd2
    } ch_state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DATA_W-1:0]  smp;
        logic               vld;
        logic               clr;
        logic               is_over;
        logic               is_clear;
        logic               clear_now;
        ch_state_t          state_q, state_d;
        logic [OVER_W-1:0]  over_q, over_d;
        logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
        logic [TIMER_W-1:0] timer_q, timer_d;
        logic               last_clear_q, last_clear_d;
        logic               trip_q, trip_d;

        assign smp       = sample_data[i*DATA_W +: DATA_W];
        assign vld       = sample_valid[i];
        assign clr       = clear_lockout[i];
        assign is_over   = vld && (smp > TRIP_TH);
        assign is_clear  = (smp <= CLEAR_TH);
        // A clear sample arriving this cycle counts immediately so re-arm is one edge later
        assign clear_now = vld ? is_clear : last_clear_q;
        assign retry_inc = retry_q + RETRY_W'(1);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q      <= ST_ARMED;
                over_q       <= '0;
                retry_q      <= '0;
                timer_q      <= TIMER_RELOAD;
                last_clear_q <= 1'b1;
                trip_q       <= 1'b0;
            end else begin
                state_q      <= state_d;
                over_q       <= over_d;
                retry_q      <= retry_d;
                timer_q      <= timer_d;
                last_clear_q <= last_clear_d;
                trip_q       <= trip_d;
            end
        end

        always_comb begin
            state_d      = state_q;
            over_d       = over_q;
            retry_d      = retry_q;
            timer_d      = timer_q;
            last_clear_d = last_clear_q;
            trip_d       = 1'b0;
            case (state_q)
                ST_ARMED: begin
                    last_clear_d = clear_now;
                    if (is_over) begin
                        timer_d = TIMER_RELOAD;
                        if (over_q == OVER_LAST) begin
                            trip_d  = 1'b1;
                            over_d  = '0;
                            retry_d = retry_inc;
                            state_d = (retry_inc > RETRY_MAX) ? ST_LOCKOUT : ST_TRIPPED;
                        end else begin
                            over_d = over_q + OVER_W'(1);
                        end
                    end else begin
                        // Healthy window runs only while no over run is in progress
                        if (over_q == '0) begin
                            if (timer_q <= TIMER_W'(1)) begin
                                retry_d = '0;
                                timer_d = TIMER_RELOAD;
                            end else begin
                                timer_d = timer_q - TIMER_W'(1);
                            end
                        end
                        if (vld) begin
                            over_d = '0;
                        end
                    end
                end
                ST_TRIPPED: begin
                    last_clear_d = clear_now;
                    if (timer_q == '0) begin
                        if (clear_now) begin
                            state_d = ST_ARMED;
                            over_d  = '0;
                            timer_d = TIMER_RELOAD;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (clr) begin
                        state_d = ST_ARMED;
                        over_d  = '0;
                        retry_d = '0;
                        timer_d = TIMER_RELOAD;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end

        assign relay[i]      = (state_q != ST_ARMED);
        assign locked[i]     = (state_q == ST_LOCKOUT);
        assign trip_event[i] = trip_q;

`ifdef OCG_PEAK_HOLD_EN
        logic [DATA_W-1:0] peak_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                peak_q <= '0;
            end else if ((state_q == ST_LOCKOUT) && clr) begin
                peak_q <= '0;
            end else if (vld && (smp > peak_q)) begin
                peak_q <= smp;
            end
        end

        assign peak_data[i*DATA_W +: DATA_W] = peak_q;
`else
        assign peak_data[i*DATA_W +: DATA_W] = '0;
`endif
    end

endmodule

// File: tb/tb_overcurrent_guard_n.sv
// tb/tb_overcurrent_guard_n.sv - scoreboard bench for overcurrent_guard_n with a behavioural channel model
module tb_overcurrent_guard_n;

    localparam int N_CH      = 3;
    localparam int DW        = 16;
    localparam int TRIP_CNT  = 3;
    localparam int RETRY_CYC = 20;
    localparam int MAX_RETRY = 2;
    localparam int TRIP_TH   = 600;
    localparam int CLEAR_TH  = 500;

    localparam int M_ARMED   = 0;
    localparam int M_TRIPPED = 1;
    localparam int M_LOCKED  = 2;

`ifdef OCG_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N_CH-1:0]    relay;
        logic [N_CH-1:0]    locked;
        logic [N_CH-1:0]    trip;
        logic [N_CH*DW-1:0] peak;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_CH*DW-1:0] sample_data = '0;
    logic [N_CH-1:0]    sample_valid = '0;
    logic [N_CH-1:0]    clear_lockout = '0;
    logic [N_CH-1:0]    relay;
    logic [N_CH-1:0]    locked;
    logic [N_CH-1:0]    trip_event;
    logic [N_CH*DW-1:0] peak_data;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Model: mode, length of the current over run, trips since last healthy window,
    // quiet ARMED cycles, cycles spent cooling, latest-sample-clear flag, peak
    int m_mode[N_CH];
    int m_run[N_CH];
    int m_trips[N_CH];
    int m_quiet[N_CH];
    int m_cool[N_CH];
    bit m_clear[N_CH];
    int m_peak[N_CH];
    bit m_trip[N_CH];

    always #5 clk = ~clk;

    overcurrent_guard_n #(
        .N_CH      (N_CH),
        .DATA_W    (DW),
        .TRIP_TH   (16'(TRIP_TH)),
        .CLEAR_TH  (16'(CLEAR_TH)),
        .TRIP_CNT  (TRIP_CNT),
        .RETRY_CYC (RETRY_CYC),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .clear_lockout (clear_lockout),
        .relay         (relay),
        .locked        (locked),
        .trip_event    (trip_event),
        .peak_data     (peak_data)
    );

    function automatic obs_t model_step(input logic rst, input logic [N_CH-1:0] v,
                                        input logic [N_CH*DW-1:0] d, input logic [N_CH-1:0] c);
        obs_t o;
        o = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            int s;
            bit over;
            s = int'(d[ch*DW +: DW]);
            over = v[ch] && (s > TRIP_TH);
            m_trip[ch] = 1'b0;
            if (rst) begin
                m_mode[ch]  = M_ARMED;
                m_run[ch]   = 0;
                m_trips[ch] = 0;
                m_quiet[ch] = 0;
                m_cool[ch]  = 0;
                m_clear[ch] = 1'b1;
                m_peak[ch]  = 0;
            end else begin
                if (v[ch] && !(m_mode[ch] == M_LOCKED && c[ch]) && s > m_peak[ch])
                    m_peak[ch] = s;
                case (m_mode[ch])
                    M_ARMED: begin
                        if (v[ch]) m_clear[ch] = (s <= CLEAR_TH);
                        if (over) begin
                            m_quiet[ch] = 0;
                            m_run[ch]   = m_run[ch] + 1;
                            if (m_run[ch] == TRIP_CNT) begin
                                m_run[ch]   = 0;
                                m_trips[ch] = m_trips[ch] + 1;
                                m_trip[ch]  = 1'b1;
                                m_cool[ch]  = 0;
                                m_mode[ch]  = (m_trips[ch] > MAX_RETRY) ? M_LOCKED : M_TRIPPED;
                            end
                        end else begin
                            if (m_run[ch] == 0) begin
                                m_quiet[ch] = m_quiet[ch] + 1;
                                if (m_quiet[ch] == RETRY_CYC) begin
                                    m_trips[ch] = 0;
                                    m_quiet[ch] = 0;
                                end
                            end
                            if (v[ch]) m_run[ch] = 0;
                        end
                    end
                    M_TRIPPED: begin
                        if (v[ch]) m_clear[ch] = (s <= CLEAR_TH);
                        if (m_cool[ch] >= RETRY_CYC && m_clear[ch]) begin
                            m_mode[ch]  = M_ARMED;
                            m_run[ch]   = 0;
                            m_quiet[ch] = 0;
                        end else begin
                            m_cool[ch] = m_cool[ch] + 1;
                        end
                    end
                    default: begin
                        if (c[ch]) begin
                            m_mode[ch]  = M_ARMED;
                            m_run[ch]   = 0;
                            m_trips[ch] = 0;
                            m_quiet[ch] = 0;
                            m_peak[ch]  = 0;
                        end
                    end
                endcase
            end
            o.relay[ch]  = (m_mode[ch] != M_ARMED);
            o.locked[ch] = (m_mode[ch] == M_LOCKED);
            o.trip[ch]   = m_trip[ch];
            o.peak[ch*DW +: DW] = PEAK_EN ? DW'(m_peak[ch]) : '0;
        end
        return o;
    endfunction

    task automatic cycle(input logic rst, input logic [N_CH-1:0] v,
                         input logic [N_CH*DW-1:0] d, input logic [N_CH-1:0] c);
        @(negedge clk);
        rst_n         = ~rst;
        sample_valid  = v;
        sample_data   = d;
        clear_lockout = c;
        exp_q.push_back(model_step(rst, v, d, c));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0);
    endtask

    task automatic send(input int ch, input logic [DW-1:0] val);
        logic [N_CH-1:0]    v;
        logic [N_CH*DW-1:0] d;
        v = '0;
        d = '0;
        v[ch] = 1'b1;
        d[ch*DW +: DW] = val;
        cycle(1'b0, v, d, '0);
    endtask

    task automatic clear_ch(input int ch);
        logic [N_CH-1:0] c;
        c = '0;
        c[ch] = 1'b1;
        cycle(1'b0, '0, '0, c);
    endtask

    task automatic trip_ch(input int ch, input logic [DW-1:0] val);
        for (int k = 0; k < TRIP_CNT; k++) send(ch, val);
    endtask

    task automatic trip_recover(input int ch, input logic [DW-1:0] val);
        trip_ch(ch, val);
        idle(3);
        send(ch, 16'd100);
        idle(RETRY_CYC + 2);
    endtask

    // Outputs produced by the edge that consumed the last driven cycle
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic void expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic logic [DW-1:0] rand_sample();
        case ($urandom_range(0, 9))
            0:       return DW'($urandom_range(0, 499));
            1:       return 16'd500;
            2:       return DW'($urandom_range(501, 599));
            3:       return 16'd600;
            4:       return 16'd601;
            5, 6, 7: return DW'($urandom_range(601, 3000));
            8:       return 16'hFFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {relay, locked, trip_event, peak_data};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got relay=%b locked=%b trip=%b peak=%h expected relay=%b locked=%b trip=%b peak=%h",
                             $time, a.relay, a.locked, a.trip, a.peak, e.relay, e.locked, e.trip, e.peak);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) cycle(1'b1, '0, '0, '0);
        settle();
        expect_eq("reset_relay", 64'(relay), 64'd0);
        expect_eq("reset_locked", 64'(locked), 64'd0);
        expect_eq("reset_trip", 64'(trip_event), 64'd0);
        expect_eq("reset_peak", 64'(peak_data), 64'd0);

        trip_ch(0, 16'd601);
        settle();
        expect_eq("trip_relay", 64'(relay), 64'b001);
        expect_eq("trip_pulse", 64'(trip_event), 64'b001);
        idle(1);
        settle();
        expect_eq("trip_pulse_end", 64'(trip_event), 64'b000);

        for (int k = 0; k < RETRY_CYC + 4; k++) send(0, 16'd550);
        settle();
        expect_eq("cooldown_hold", 64'(relay[0]), 64'd1);
        send(0, 16'd500);
        settle();
        expect_eq("rearm_on_clear", 64'(relay[0]), 64'd0);

        send(0, 16'd601);
        send(0, 16'd601);
        send(0, 16'd600);
        send(0, 16'd601);
        send(0, 16'd601);
        settle();
        expect_eq("broken_run_relay", 64'(relay[0]), 64'd0);
        send(0, 16'd0);

        trip_recover(2, 16'hFFFF);
        trip_recover(2, 16'hFFFF);
        trip_ch(2, 16'hFFFF);
        settle();
        expect_eq("lockout_locked", 64'(locked[2]), 64'd1);
        expect_eq("lockout_relay", 64'(relay[2]), 64'd1);
        idle(40);
        settle();
        expect_eq("lockout_hold", 64'(locked[2]), 64'd1);
        cycle(1'b0, 3'b100, {16'hFFFF, 32'h0}, 3'b100);
        settle();
        expect_eq("lockout_release", 64'(locked[2]), 64'd0);
        expect_eq("release_relay", 64'(relay[2]), 64'd0);
        expect_eq("release_peak", 64'(peak_data[2*DW +: DW]), 64'd0);

        trip_recover(1, 16'd700);
        trip_recover(1, 16'd700);
        idle(RETRY_CYC + 5);
        trip_recover(1, 16'd700);
        settle();
        expect_eq("window_locked_a", 64'(locked[1]), 64'd0);
        trip_recover(1, 16'd700);
        settle();
        expect_eq("window_locked_b", 64'(locked[1]), 64'd0);
        expect_eq("window_relay", 64'(relay[1]), 64'd0);

        send(1, 16'd100);
        send(1, 16'd750);
        send(1, 16'd300);
        settle();
        expect_eq("peak_max", 64'(peak_data[1*DW +: DW]), PEAK_EN ? 64'd750 : 64'd0);
        trip_ch(1, 16'd700);
        settle();
        expect_eq("peak_lock", 64'(locked[1]), 64'd1);
        clear_ch(1);
        settle();
        expect_eq("peak_clear", 64'(peak_data[1*DW +: DW]), 64'd0);
        expect_eq("peak_unlock", 64'(locked[1]), 64'd0);

        trip_ch(0, 16'd900);
        idle(5);
        settle();
        expect_eq("cool_relay", 64'(relay[0]), 64'd1);
        expect_eq("cool_peak", 64'(peak_data[0*DW +: DW]), PEAK_EN ? 64'd900 : 64'd0);
        cycle(1'b1, '0, '0, '0);
        settle();
        expect_eq("midcool_reset_relay", 64'(relay), 64'd0);
        expect_eq("midcool_reset_peak", 64'(peak_data), 64'd0);

        for (int blk = 0; blk < 30; blk++) begin
            int busy;
            busy = $urandom_range(1, 6);
            for (int n = 0; n < 100; n++) begin
                logic [N_CH-1:0]    v;
                logic [N_CH-1:0]    c;
                logic [N_CH*DW-1:0] d;
                logic               r;
                for (int ch = 0; ch < N_CH; ch++) begin
                    v[ch] = ($urandom_range(0, 9) < busy);
                    c[ch] = ($urandom_range(0, 15) == 0);
                    d[ch*DW +: DW] = rand_sample();
                end
                r = ($urandom_range(0, 399) == 0);
                cycle(r, v, d, c);
            end
        end

        settle();
        expect_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
